// File: rtl/status_ctrl.sv
// STATUS register update arbiter for PIC16F: merges ALU/file writes with
// watchdog and RUN/SLEEP/WAKE power-state events into one write port.
module status_ctrl #(
  parameter int WDT_WIDTH   = 16,
  parameter int WAKE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] status_cur,
  input  logic       file_wr,
  input  logic [7:0] file_wr_data,
  input  logic [2:0] alu_flag_wr,
  input  logic [2:0] alu_flags,
  input  logic       instr_sleep,
  input  logic       instr_clrwdt,
  input  logic       wdt_en,
  input  logic       wake_event,
  output logic       status_wr,
  output logic [7:0] status_reg_in,
  output logic       cpu_stall,
  output logic       sleeping,
  output logic       wdt_reset
);

  typedef enum logic [1:0] {ST_RUN, ST_SLEEP, ST_WAKE} state_t;

  localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);

  state_t               r_state;
  logic [WDT_WIDTH-1:0] r_wdt;
  logic [7:0]           r_wake_cnt;

  logic       w_timeout;
  logic [7:0] w_merge;

  // WAKE holds the counter at zero, so a timeout can only arise in RUN or SLEEP
  assign w_timeout = wdt_en && (r_state != ST_WAKE) && (&r_wdt);

  always_comb begin
    w_merge[7:5] = file_wr ? file_wr_data[7:5] : status_cur[7:5];
    w_merge[4:3] = status_cur[4:3];
    for (int i = 0; i < 3; i++) begin
      if (alu_flag_wr[i])
        w_merge[i] = alu_flags[i];
      else if (file_wr)
        w_merge[i] = file_wr_data[i];
      else
        w_merge[i] = status_cur[i];
    end
  end

  always_comb begin
    status_wr     = 1'b0;
    status_reg_in = w_merge;
    wdt_reset     = 1'b0;
    if (rst) begin
      status_wr     = 1'b1;
      status_reg_in = 8'h18;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (instr_sleep) begin
            status_wr     = 1'b1;
            status_reg_in = {w_merge[7:5], 2'b10, w_merge[2:0]};
          end else if (instr_clrwdt) begin
            status_wr     = 1'b1;
            status_reg_in = {w_merge[7:5], 2'b11, w_merge[2:0]};
          end else if (w_timeout) begin
            status_wr     = 1'b1;
            status_reg_in = {3'b000, 2'b01, status_cur[2:0]};
            wdt_reset     = 1'b1;
          end else begin
            status_wr = file_wr || (|alu_flag_wr);
          end
        end
        ST_SLEEP: begin
          if (w_timeout) begin
            status_wr     = 1'b1;
            status_reg_in = {status_cur[7:5], 2'b00, status_cur[2:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_stall = !rst && (r_state != ST_RUN);
  assign sleeping  = !rst && (r_state == ST_SLEEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wdt      <= '0;
      r_wake_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_wake_cnt <= '0;
          if (instr_sleep) begin
            r_state <= ST_SLEEP;
            r_wdt   <= '0;
          end else if (instr_clrwdt || w_timeout || !wdt_en) begin
            r_wdt <= '0;
          end else begin
            r_wdt <= r_wdt + WDT_WIDTH'(1);
          end
        end
        ST_SLEEP: begin
          r_wake_cnt <= '0;
          if (w_timeout || wake_event) begin
            r_state <= ST_WAKE;
            r_wdt   <= '0;
          end else if (!wdt_en) begin
            r_wdt <= '0;
          end else begin
            r_wdt <= r_wdt + WDT_WIDTH'(1);
          end
        end
        ST_WAKE: begin
          r_wdt <= '0;
          if (r_wake_cnt == WAKE_LAST) begin
            r_state    <= ST_RUN;
            r_wake_cnt <= '0;
          end else begin
            r_wake_cnt <= r_wake_cnt + 8'd1;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_wdt      <= '0;
          r_wake_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_status_ctrl.sv
// Bench for status_ctrl with a 4-bit watchdog and 4-cycle wake stall:
// directed scenarios followed by a randomized run against a behavioural model.
module tb_status_ctrl;
  localparam int WDTW = 4;
  localparam int WAKE = 4;
  localparam int WDT_MAX = (1 << WDTW) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] status_cur;
  logic       file_wr;
  logic [7:0] file_wr_data;
  logic [2:0] alu_flag_wr;
  logic [2:0] alu_flags;
  logic       instr_sleep;
  logic       instr_clrwdt;
  logic       wdt_en;
  logic       wake_event;
  logic       status_wr;
  logic [7:0] status_reg_in;
  logic       cpu_stall;
  logic       sleeping;
  logic       wdt_reset;

  int n_chk  = 0;
  int n_pass = 0;

  status_ctrl #(.WDT_WIDTH(WDTW), .WAKE_CYCLES(WAKE)) dut (
    .clk(clk), .rst(rst), .status_cur(status_cur), .file_wr(file_wr),
    .file_wr_data(file_wr_data), .alu_flag_wr(alu_flag_wr), .alu_flags(alu_flags),
    .instr_sleep(instr_sleep), .instr_clrwdt(instr_clrwdt), .wdt_en(wdt_en),
    .wake_event(wake_event), .status_wr(status_wr), .status_reg_in(status_reg_in),
    .cpu_stall(cpu_stall), .sleeping(sleeping), .wdt_reset(wdt_reset)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    file_wr = 1'b0; file_wr_data = 8'h00; alu_flag_wr = 3'b000; alu_flags = 3'b000;
    instr_sleep = 1'b0; instr_clrwdt = 1'b0; wake_event = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    wdt_en = 1'b0; status_cur = 8'hFF; rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++;
      if ({status_wr, status_reg_in, cpu_stall, sleeping, wdt_reset} !== {1'b1, 8'h18, 3'b000})
        $display("FAIL reset_outputs cyc%0d: got wr=%0b reg=%h stall=%0b slp=%0b wrst=%0b expected wr=1 reg=18 others 0",
                 c, status_wr, status_reg_in, cpu_stall, sleeping, wdt_reset);
      else n_pass++;
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_merge();
    wdt_en = 1'b0; do_reset();
    status_cur = 8'h18; file_wr = 1'b1; file_wr_data = 8'hE7;
    alu_flag_wr = 3'b100; alu_flags = 3'b000;
    #1; n_chk++;
    if (status_wr !== 1'b1 || status_reg_in !== 8'hFB)
      $display("FAIL merge_file_alu: got wr=%0b reg=%h expected wr=1 reg=fb", status_wr, status_reg_in);
    else n_pass++;
    tick();
    idle_inputs(); status_cur = 8'h3A; alu_flag_wr = 3'b011; alu_flags = 3'b101;
    #1; n_chk++;
    if (status_wr !== 1'b1 || status_reg_in !== 8'h39)
      $display("FAIL merge_alu_only: got wr=%0b reg=%h expected wr=1 reg=39", status_wr, status_reg_in);
    else n_pass++;
    tick();
    idle_inputs(); file_wr_data = 8'hFF;
    #1; n_chk++;
    if (status_wr !== 1'b0)
      $display("FAIL merge_no_source: got wr=%0b expected 0", status_wr);
    else n_pass++;
    tick();
  endtask

  task automatic test_clrwdt_timeout();
    int nwr;
    wdt_en = 1'b1; do_reset();
    status_cur = 8'h05; nwr = 0;
    for (int c = 0; c < 15; c++) begin
      #1; if (status_wr || wdt_reset) nwr++;
      tick();
    end
    instr_clrwdt = 1'b1;
    #1; n_chk++;
    if (nwr != 0 || status_wr !== 1'b1 || status_reg_in !== 8'h1D || wdt_reset !== 1'b0)
      $display("FAIL clrwdt_on_timeout: got early=%0d wr=%0b reg=%h wrst=%0b expected early=0 wr=1 reg=1d wrst=0",
               nwr, status_wr, status_reg_in, wdt_reset);
    else n_pass++;
    tick();
    instr_clrwdt = 1'b0; status_cur = 8'hE5; nwr = 0;
    for (int c = 0; c < 15; c++) begin
      #1; if (status_wr || wdt_reset) nwr++;
      tick();
    end
    #1; n_chk++;
    if (nwr != 0 || status_wr !== 1'b1 || status_reg_in !== 8'h0D || wdt_reset !== 1'b1)
      $display("FAIL run_timeout: got early=%0d wr=%0b reg=%h wrst=%0b expected early=0 wr=1 reg=0d wrst=1",
               nwr, status_wr, status_reg_in, wdt_reset);
    else n_pass++;
    tick();
    #1; n_chk++;
    if (wdt_reset !== 1'b0 || status_wr !== 1'b0)
      $display("FAIL timeout_one_cycle: got wrst=%0b wr=%0b expected 0 0", wdt_reset, status_wr);
    else n_pass++;
    tick();
    wdt_en = 1'b0;
  endtask

  task automatic test_sleep_wake();
    int n;
    wdt_en = 1'b0; do_reset();
    status_cur = 8'h18; instr_sleep = 1'b1;
    #1; n_chk++;
    if (status_wr !== 1'b1 || status_reg_in !== 8'h10 || sleeping !== 1'b0)
      $display("FAIL sleep_entry: got wr=%0b reg=%h slp=%0b expected 1 10 0", status_wr, status_reg_in, sleeping);
    else n_pass++;
    tick();
    instr_sleep = 1'b0; status_cur = 8'h10; file_wr = 1'b1; file_wr_data = 8'hAA;
    alu_flag_wr = 3'b111; instr_clrwdt = 1'b1;
    #1; n_chk++;
    if (status_wr !== 1'b0 || sleeping !== 1'b1 || cpu_stall !== 1'b1)
      $display("FAIL sleep_ignores_writes: got wr=%0b slp=%0b stall=%0b expected 0 1 1", status_wr, sleeping, cpu_stall);
    else n_pass++;
    tick();
    idle_inputs(); wake_event = 1'b1;
    n = 0;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (!cpu_stall) break;
      n++;
      tick(); wake_event = 1'b0;
      #1;
    end
    n_chk++;
    if (n != WAKE + 1 || sleeping !== 1'b0)
      $display("FAIL wake_stall_len: got %0d cycles slp=%0b expected %0d cycles slp=0", n, sleeping, WAKE + 1);
    else n_pass++;
    tick();
  endtask

  task automatic test_wdt_wake();
    int nwr, n;
    wdt_en = 1'b1; do_reset();
    status_cur = 8'h18; instr_sleep = 1'b1;
    #1; tick();
    instr_sleep = 1'b0; status_cur = 8'h10; nwr = 0;
    for (int c = 0; c < 15; c++) begin
      #1; if (status_wr || !sleeping) nwr++;
      tick();
    end
    #1; n_chk++;
    if (nwr != 0 || status_wr !== 1'b1 || status_reg_in !== 8'h00 || wdt_reset !== 1'b0)
      $display("FAIL sleep_wdt_timeout: got early=%0d wr=%0b reg=%h wrst=%0b expected 0 1 00 0",
               nwr, status_wr, status_reg_in, wdt_reset);
    else n_pass++;
    tick();
    n = 0;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (!cpu_stall || sleeping) break;
      n++;
      tick(); #1;
    end
    n_chk++;
    if (n != WAKE || cpu_stall !== 1'b0)
      $display("FAIL wdt_wake_to_run: got wake=%0d stall=%0b expected wake=%0d stall=0", n, cpu_stall, WAKE);
    else n_pass++;
    tick();
    wdt_en = 1'b0;
  endtask

  task automatic test_reset_mid_wake();
    wdt_en = 1'b0; do_reset();
    status_cur = 8'hFF; instr_sleep = 1'b1; tick();
    instr_sleep = 1'b0; wake_event = 1'b1; tick();
    wake_event = 1'b0; tick();
    rst = 1'b1;
    #1; n_chk++;
    if (cpu_stall !== 1'b0 || status_wr !== 1'b1)
      $display("FAIL rst_in_wake_now: got stall=%0b wr=%0b expected 0 1", cpu_stall, status_wr);
    else n_pass++;
    tick();
    #1; n_chk++;
    if (cpu_stall !== 1'b0 || sleeping !== 1'b0 || status_reg_in !== 8'h18)
      $display("FAIL rst_in_wake_next: got stall=%0b slp=%0b reg=%h expected 0 0 18", cpu_stall, sleeping, status_reg_in);
    else n_pass++;
    tick();
    rst = 1'b0;
    #1; n_chk++;
    if (cpu_stall !== 1'b0 || status_wr !== 1'b0)
      $display("FAIL rst_release_run: got stall=%0b wr=%0b expected 0 0", cpu_stall, status_wr);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int mode, wdt, wk, nbad;
    logic e_wr, e_stall, e_slp, e_wrst;
    logic [7:0] e_reg, mrg, a_reg;
    mode = 0; wdt = 0; wk = 0; nbad = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst          = ($urandom_range(0, 79) == 0);
      status_cur   = 8'($urandom);
      file_wr      = ($urandom_range(0, 2) == 0);
      file_wr_data = 8'($urandom);
      alu_flag_wr  = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
      alu_flags    = 3'($urandom);
      instr_sleep  = ($urandom_range(0, 11) == 0);
      instr_clrwdt = ($urandom_range(0, 9) == 0);
      wdt_en       = ($urandom_range(0, 7) != 0);
      wake_event   = ($urandom_range(0, 9) == 0);
      #1;
      mrg[7:5] = file_wr ? file_wr_data[7:5] : status_cur[7:5];
      mrg[4:3] = status_cur[4:3];
      for (int i = 0; i < 3; i++)
        mrg[i] = alu_flag_wr[i] ? alu_flags[i] : (file_wr ? file_wr_data[i] : status_cur[i]);
      e_wr = 1'b0; e_reg = 8'h00; e_wrst = 1'b0;
      e_stall = (mode != 0); e_slp = (mode == 1);
      if (rst) begin
        e_wr = 1'b1; e_reg = 8'h18; e_stall = 1'b0; e_slp = 1'b0;
        mode = 0; wdt = 0; wk = 0;
      end else if (mode == 0) begin
        if (instr_sleep || instr_clrwdt) begin
          e_wr = 1'b1; e_reg = mrg; e_reg[4] = 1'b1; e_reg[3] = !instr_sleep;
          if (instr_sleep) mode = 1;
          wdt = 0;
        end else if (wdt_en && wdt == WDT_MAX) begin
          e_wr = 1'b1; e_reg = {5'b00001, status_cur[2:0]}; e_wrst = 1'b1; wdt = 0;
        end else begin
          e_wr = file_wr || (alu_flag_wr != 3'b000);
          if (e_wr) e_reg = mrg;
          wdt = wdt_en ? wdt + 1 : 0;
        end
      end else if (mode == 1) begin
        if (wdt_en && wdt == WDT_MAX) begin
          e_wr = 1'b1; e_reg = status_cur & 8'hE7; mode = 2; wk = 0; wdt = 0;
        end else if (wake_event) begin
          mode = 2; wk = 0; wdt = 0;
        end else begin
          wdt = wdt_en ? wdt + 1 : 0;
        end
      end else begin
        wdt = 0; wk++;
        if (wk == WAKE) mode = 0;
      end
      a_reg = e_wr ? status_reg_in : 8'h00;
      n_chk++;
      if ({status_wr, a_reg, cpu_stall, sleeping, wdt_reset} !== {e_wr, e_reg, e_stall, e_slp, e_wrst}) begin
        if (nbad < 10)
          $display("FAIL random_cyc%0d: got wr=%0b reg=%h stall=%0b slp=%0b wrst=%0b expected wr=%0b reg=%h stall=%0b slp=%0b wrst=%0b",
                   c, status_wr, a_reg, cpu_stall, sleeping, wdt_reset, e_wr, e_reg, e_stall, e_slp, e_wrst);
        nbad++;
      end else n_pass++;
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wdt_en = 1'b0; status_cur = 8'h00;
    idle_inputs();
    #1;
    test_reset();
    test_merge();
    test_clrwdt_timeout();
    test_sleep_wake();
    test_wdt_wake();
    test_reset_mid_wake();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
